// File: rtl/bscan_user_dr_if.sv
// BSCANE2 user-chain signal bundle: TAP-side strobes and serial data in, serial data out.
interface bscan_user_dr_if;
  logic ir_is_user;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdi;
  logic tdo;

  modport master (
    output ir_is_user, capture_dr, shift_dr, update_dr, tdi,
    input  tdo
  );

  modport slave (
    input  ir_is_user, capture_dr, shift_dr, update_dr, tdi,
    output tdo
  );
endinterface

// File: rtl/bscan_user_dr.sv
// JTAG USER data-register endpoint: framed DR scans write a small register bank,
// the next capture returns the last-addressed register, wrong-length frames flag a sticky error.
module bscan_user_dr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    LOOPBACK   = 0,
  parameter logic [DATA_WIDTH-1:0] REG_RESET  = '0
) (
  input  logic                                   tck,
  input  logic                                   rst_n,
  bscan_user_dr_if.slave                         jtag,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  regs,
  output logic [(2**ADDR_WIDTH)-1:0]             wr_strobe,
  output logic                                   frame_err,
  output logic [15:0]                            frame_cnt
);

  localparam int NUM_REGS    = 2**ADDR_WIDTH;
  localparam int FRAME_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int BCNT_W      = $clog2(FRAME_WIDTH + 2);

  localparam logic [BCNT_W-1:0] BCNT_FRAME = BCNT_W'(FRAME_WIDTH);
  localparam logic [BCNT_W-1:0] BCNT_SAT   = BCNT_W'(FRAME_WIDTH + 1);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 wr_strobe_q, wr_strobe_d;
  logic [FRAME_WIDTH-1:0]              sr_q, sr_d;
  logic [BCNT_W-1:0]                   bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0]               rd_addr_q, rd_addr_d;
  logic                                frame_err_q, frame_err_d;
  logic [15:0]                         frame_cnt_q, frame_cnt_d;

  logic [DATA_WIDTH-1:0] frame_data;
  logic [ADDR_WIDTH-1:0] frame_addr;
  logic                  frame_wr;

  assign frame_data = sr_q[DATA_WIDTH-1:0];
  assign frame_addr = sr_q[DATA_WIDTH +: ADDR_WIDTH];
  assign frame_wr   = sr_q[FRAME_WIDTH-1];

  // Capture outranks shift, which outranks update; nothing moves unless the USER IR is selected.
  always_comb begin
    regs_d      = regs_q;
    wr_strobe_d = '0;
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    rd_addr_d   = rd_addr_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;

    if (jtag.ir_is_user) begin
      if (jtag.capture_dr) begin
        sr_d   = {frame_err_q, rd_addr_q, regs_q[rd_addr_q]};
        bcnt_d = '0;
      end else if (jtag.shift_dr) begin
        sr_d = {jtag.tdi, sr_q[FRAME_WIDTH-1:1]};
        if (bcnt_q != BCNT_SAT) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end else if (jtag.update_dr) begin
        // bcnt survives the update, so a repeated update re-applies the same frame.
        if (bcnt_q == BCNT_FRAME) begin
          rd_addr_d   = frame_addr;
          frame_err_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (frame_wr && (LOOPBACK == 0)) begin
            regs_d[frame_addr]      = frame_data;
            wr_strobe_d[frame_addr] = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      regs_q      <= {NUM_REGS{REG_RESET}};
      wr_strobe_q <= '0;
      sr_q        <= '0;
      bcnt_q      <= '0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // TDO comes straight off the shift register so the TAP can sample it on the falling edge.
  assign jtag.tdo  = (LOOPBACK != 0) ? jtag.tdi : sr_q[0];
  assign regs      = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bscan_user_dr.sv
// Directed bench for bscan_user_dr: a normal build and a LOOPBACK build side by side.
module tb_bscan_user_dr;

  logic tck = 1'b0;
  logic rst_n;
  always #5 tck = ~tck;

  bscan_user_dr_if j0 ();
  bscan_user_dr_if j1 ();

  logic [127:0] regs0, regs1;
  logic [3:0]   wrs0, wrs1;
  logic         err0, err1;
  logic [15:0]  cnt0, cnt1;

  bscan_user_dr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .LOOPBACK(0), .REG_RESET(32'h0)
  ) u0 (
    .tck(tck), .rst_n(rst_n), .jtag(j0),
    .regs(regs0), .wr_strobe(wrs0), .frame_err(err0), .frame_cnt(cnt0)
  );

  bscan_user_dr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .LOOPBACK(1), .REG_RESET(32'h5A5A0F0F)
  ) u1 (
    .tck(tck), .rst_n(rst_n), .jtag(j1),
    .regs(regs1), .wr_strobe(wrs1), .frame_err(err1), .frame_cnt(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each helper is entered at a falling edge and leaves at the next falling edge.
  task automatic cyc0(input logic cap, input logic sh, input logic upd, input logic d);
    j0.capture_dr = cap;
    j0.shift_dr   = sh;
    j0.update_dr  = upd;
    j0.tdi        = d;
    @(posedge tck);
    @(negedge tck);
    j0.capture_dr = 1'b0;
    j0.shift_dr   = 1'b0;
    j0.update_dr  = 1'b0;
  endtask

  task automatic shift0(input logic [63:0] bits, input int n, output logic [63:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      j0.shift_dr = 1'b1;
      j0.tdi      = bits[i];
      #1;
      rd[i] = j0.tdo;
      @(posedge tck);
      @(negedge tck);
    end
    j0.shift_dr = 1'b0;
    j0.tdi      = 1'b0;
  endtask

  logic [63:0] frame, rd;

  initial begin
    rst_n = 1'b0;
    j0.ir_is_user = 1'b1; j0.capture_dr = 1'b0; j0.shift_dr = 1'b0;
    j0.update_dr  = 1'b0; j0.tdi = 1'b0;
    j1.ir_is_user = 1'b0; j1.capture_dr = 1'b0; j1.shift_dr = 1'b0;
    j1.update_dr  = 1'b0; j1.tdi = 1'b0;
    repeat (3) @(negedge tck);

    chk("rst_regs",  regs0, 128'h0);
    chk("rst_wrs",   wrs0,  4'h0);
    chk("rst_err",   err0,  1'b0);
    chk("rst_cnt",   cnt0,  16'd0);
    chk("rst_tdo",   j0.tdo, 1'b0);
    chk("lb_rst_regs", regs1, {4{32'h5A5A0F0F}});
    rst_n = 1'b1;
    cyc0(0, 0, 0, 0);

    // Write 0xDEADBEEF to reg 2.
    frame = {29'h0, 1'b1, 2'b10, 32'hDEADBEEF};
    cyc0(1, 0, 0, 0);
    shift0(frame, 35, rd);
    chk("wr_capture_rd", rd, 64'h0);
    cyc0(0, 0, 1, 0);
    chk("wr_strobe", wrs0, 4'b0100);
    chk("wr_regs",   regs0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    chk("wr_cnt",    cnt0,  16'd1);
    chk("wr_err",    err0,  1'b0);
    cyc0(0, 0, 0, 0);
    chk("wr_strobe_pulse", wrs0, 4'b0000);

    // Readback of reg 2, then an all-zero read frame.
    cyc0(1, 0, 0, 0);
    shift0(64'h0, 35, rd);
    chk("rd_data", rd, 64'h2_DEADBEEF);
    cyc0(0, 0, 1, 0);
    chk("rd_cnt",  cnt0,  16'd2);
    chk("rd_wrs",  wrs0,  4'b0000);
    chk("rd_regs", regs0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});

    // Short frame: 34 shifts of a write to reg 1.
    frame = {29'h0, 1'b1, 2'b01, 32'h12345678};
    cyc0(1, 0, 0, 0);
    shift0(frame, 34, rd);
    cyc0(0, 0, 1, 0);
    chk("short_wrs",  wrs0,  4'b0000);
    chk("short_regs", regs0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    chk("short_err",  err0,  1'b1);
    chk("short_cnt",  cnt0,  16'd2);
    cyc0(1, 0, 0, 0);
    shift0(64'h0, 35, rd);
    chk("short_cap_err_bit", rd, 64'h4_00000000);
    cyc0(0, 0, 1, 0);
    chk("short_clear_err", err0, 1'b0);
    chk("short_clear_cnt", cnt0, 16'd3);

    // Strobes ignored while the USER IR is not selected.
    j0.ir_is_user = 1'b0;
    cyc0(0, 0, 1, 0);
    chk("gate_upd_cnt", cnt0, 16'd3);
    shift0({64{1'b1}}, 35, rd);
    chk("gate_shift_tdo", j0.tdo, 1'b0);
    cyc0(1, 0, 0, 0);
    chk("gate_regs", regs0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    chk("gate_err",  err0,  1'b0);
    j0.ir_is_user = 1'b1;
    cyc0(0, 0, 1, 0);
    chk("reupdate_cnt", cnt0, 16'd4);
    chk("reupdate_err", err0, 1'b0);

    // Long frame of 40 shifts.
    frame = {29'h0, 1'b1, 2'b01, 32'hCAFEF00D};
    cyc0(1, 0, 0, 0);
    shift0(frame, 40, rd);
    cyc0(0, 0, 1, 0);
    chk("long_err",  err0,  1'b1);
    chk("long_wrs",  wrs0,  4'b0000);
    chk("long_regs", regs0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    chk("long_cnt",  cnt0,  16'd4);

    // Reset in the middle of a write frame, with shift still asserted.
    frame = {29'h0, 1'b1, 2'b11, 32'h0BADF00D};
    cyc0(1, 0, 0, 0);
    shift0(frame, 20, rd);
    rst_n = 1'b0;
    cyc0(0, 1, 0, 1);
    rst_n = 1'b1;
    chk("mid_rst_regs", regs0, 128'h0);
    chk("mid_rst_err",  err0,  1'b0);
    chk("mid_rst_cnt",  cnt0,  16'd0);
    chk("mid_rst_tdo",  j0.tdo, 1'b0);
    chk("mid_rst_wrs",  wrs0,  4'b0000);
    cyc0(0, 0, 1, 0);
    chk("mid_rst_upd_regs", regs0, 128'h0);
    chk("mid_rst_upd_wrs",  wrs0,  4'b0000);
    chk("mid_rst_upd_cnt",  cnt0,  16'd0);
    chk("mid_rst_upd_err",  err0,  1'b1);
    cyc0(1, 0, 0, 0);
    shift0(frame, 35, rd);
    cyc0(0, 0, 1, 0);
    chk("reg3_wrs",  wrs0,  4'b1000);
    chk("reg3_regs", regs0, {32'h0BADF00D, 96'h0});
    chk("reg3_cnt",  cnt0,  16'd1);
    chk("reg3_err",  err0,  1'b0);

    // LOOPBACK build: tdo follows tdi with no clock in between.
    j1.ir_is_user = 1'b1;
    j1.shift_dr   = 1'b1;
    j1.tdi = 1'b1; #1; chk("lb_tdo_1", j1.tdo, 1'b1);
    j1.tdi = 1'b0; #1; chk("lb_tdo_0", j1.tdo, 1'b0);
    j1.tdi = 1'b1; #1; chk("lb_tdo_1b", j1.tdo, 1'b1);
    j1.shift_dr = 1'b0;
    @(negedge tck);
    j1.capture_dr = 1'b1;
    @(posedge tck); @(negedge tck);
    j1.capture_dr = 1'b0;
    frame = {29'h0, 1'b1, 2'b01, 32'h13572468};
    for (int i = 0; i < 35; i++) begin
      j1.shift_dr = 1'b1;
      j1.tdi      = frame[i];
      @(posedge tck); @(negedge tck);
    end
    j1.shift_dr  = 1'b0;
    j1.update_dr = 1'b1;
    @(posedge tck); @(negedge tck);
    j1.update_dr = 1'b0;
    chk("lb_regs", regs1, {4{32'h5A5A0F0F}});
    chk("lb_wrs",  wrs1,  4'b0000);
    chk("lb_cnt",  cnt1,  16'd1);
    chk("lb_err",  err1,  1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
